// File: rtl/lsu_split_if.sv
// Request, response and data-memory signals of the load/store unit.
// slave is the LSU side; master is the pipeline plus memory side.
interface lsu_split_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_wen;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_type;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_wen, mem_ren, mem_addr, mem_type, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_wen, mem_ren, mem_addr, mem_type, mem_wdata
  );
endinterface

// File: rtl/lsu_split.sv
// Load/store unit: aligned accesses take one memory cycle. With LSU_MISALIGN_SPLIT_EN
// misaligned accesses become byte accesses; without it they are rejected with rsp_err.
module lsu_split #(
  parameter int unsigned ADDR_W = 32
) (
  input logic        clk,
  input logic        rst,
  lsu_split_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic req_fire, req_illegal, req_aligned, req_err, acc_done;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic       split_q, split_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] cnt_last;
`endif

  assign req_fire = bus.req_valid && (state_q == StIdle);

  always_comb begin
    req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
    case (bus.req_funct3[1:0])
      2'b00:   req_aligned = 1'b1;
      2'b01:   req_aligned = ~bus.req_addr[0];
      2'b10:   req_aligned = (bus.req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign req_err  = req_illegal;
  assign cnt_last = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign acc_done = !split_q || (cnt_q == cnt_last);
`else
  assign req_err  = req_illegal || !req_aligned;
  assign acc_done = 1'b1;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      cnt_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      err_q    <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= split_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_fire) state_d = req_err ? StResp : StAcc;
      StAcc:   if (acc_done) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture and load-data assembly
  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    err_d    = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d  = split_q;
    cnt_d    = cnt_q;
`endif
    if (req_fire) begin
      we_d     = bus.req_we;
      funct3_d = bus.req_funct3;
      addr_d   = bus.req_addr;
      wdata_d  = bus.req_wdata;
      data_d   = '0;
      err_d    = req_err;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_d  = !req_aligned && !req_illegal;
      cnt_d    = 2'd0;
`endif
    end else if (state_q == StAcc) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      if (split_q) begin
        if (!we_q) data_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
        cnt_d = cnt_q + 2'd1;
      end else if (!we_q) begin
        data_d = bus.mem_rdata;
      end
`else
      if (!we_q) data_d = bus.mem_rdata;
`endif
    end
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_err   = (state_q == StResp) && err_q;
    bus.rsp_rdata = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_type  = 3'b000;
    bus.mem_wdata = '0;

    if ((state_q == StResp) && !err_q && !we_q) begin
      case (funct3_q)
        3'b000:  bus.rsp_rdata = {{24{data_q[7]}}, data_q[7:0]};
        3'b001:  bus.rsp_rdata = {{16{data_q[15]}}, data_q[15:0]};
        3'b010:  bus.rsp_rdata = data_q;
        3'b100:  bus.rsp_rdata = {24'h0, data_q[7:0]};
        3'b101:  bus.rsp_rdata = {16'h0, data_q[15:0]};
        default: bus.rsp_rdata = '0;
      endcase
    end

    if (state_q == StAcc) begin
      // Strobes are masked by reset so an aborted access never writes on the reset edge.
      bus.mem_wen   = we_q && !rst;
      bus.mem_ren   = !we_q && !rst;
      bus.mem_addr  = addr_q;
      bus.mem_type  = funct3_q;
      bus.mem_wdata = wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (split_q) begin
        bus.mem_addr  = addr_q + ADDR_W'(cnt_q);
        bus.mem_type  = 3'b100;
        bus.mem_wdata = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split with a byte-array memory model; split-access scenarios
// are selected by LSU_MISALIGN_SPLIT_EN to match the build of the design.
module tb_lsu_split;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_split_if #(.ADDR_W(32)) bus ();
  lsu_split #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [256];
  logic       mem_clr, pk_en;
  logic [7:0] pk_a, pk_d;
  logic [7:0] ma0, ma1, ma2, ma3;

  int vec  = 0;
  int miss = 0;

  assign ma0 = bus.mem_addr[7:0];
  assign ma1 = ma0 + 8'd1;
  assign ma2 = ma0 + 8'd2;
  assign ma3 = ma0 + 8'd3;
  assign bus.mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};

  // Little-endian memory; data is right-justified on both read and write.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (pk_en) begin
      mem[pk_a] <= pk_d;
    end else if (bus.mem_wen) begin
      mem[ma0] <= bus.mem_wdata[7:0];
      if (bus.mem_type[1:0] != 2'b00) mem[ma1] <= bus.mem_wdata[15:8];
      if (bus.mem_type[1:0] == 2'b10) begin
        mem[ma2] <= bus.mem_wdata[23:16];
        mem[ma3] <= bus.mem_wdata[31:24];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, want finish within bound");
    $fatal(1);
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Returns during cycle T+1, where T is the edge that transfers the request.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_clr = 1'b1; pk_en = 1'b0; pk_a = 8'h0; pk_d = 8'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    vec++; if (bus.req_ready !== 1'b1) begin miss++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    vec++; if (bus.rsp_valid !== 1'b0) begin miss++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    vec++; if (bus.mem_wen !== 1'b0) begin miss++; $display("FAIL rst_wen: got %b want 0", bus.mem_wen); end
    vec++; if (bus.mem_ren !== 1'b0) begin miss++; $display("FAIL rst_ren: got %b want 0", bus.mem_ren); end
    vec++; if (bus.mem_addr !== 32'h0) begin miss++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
    vec++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.mem_type !== 3'b000 || bus.mem_wdata !== 32'h0) begin
      miss++; $display("FAIL rst_others: got rdata %h err %b type %b wdata %h want all 0",
                       bus.rsp_rdata, bus.rsp_err, bus.mem_type, bus.mem_wdata); end
  endtask

  task automatic test_aligned_load;
    poke(8'h10, 8'hFF); poke(8'h11, 8'h00); poke(8'h12, 8'h00); poke(8'h13, 8'h80);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    vec++; if (bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0) begin miss++; $display("FAIL lw_strobe: got ren %b wen %b want 1 0", bus.mem_ren, bus.mem_wen); end
    vec++; if (bus.mem_addr !== 32'h10) begin miss++; $display("FAIL lw_addr: got %h want 00000010", bus.mem_addr); end
    vec++; if (bus.mem_type !== 3'b010) begin miss++; $display("FAIL lw_type: got %b want 010", bus.mem_type); end
    vec++; if (bus.rsp_valid !== 1'b0) begin miss++; $display("FAIL lw_early_rsp: got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    vec++; if (bus.rsp_valid !== 1'b1) begin miss++; $display("FAIL lw_rsp_valid: got %b want 1", bus.rsp_valid); end
    vec++; if (bus.rsp_rdata !== 32'h800000FF) begin miss++; $display("FAIL lw_rdata: got %h want 800000ff", bus.rsp_rdata); end
    vec++; if (bus.rsp_err !== 1'b0 || bus.mem_ren !== 1'b0 || bus.mem_addr !== 32'h0) begin
      miss++; $display("FAIL lw_resp_quiet: got err %b ren %b addr %h want 0 0 0", bus.rsp_err, bus.mem_ren, bus.mem_addr); end
    @(negedge clk);
    vec++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miss++; $display("FAIL lw_idle: got valid %b ready %b want 0 1", bus.rsp_valid, bus.req_ready); end

    issue(1'b0, 3'b000, 32'h10, 32'h0);
    vec++; if (bus.mem_type !== 3'b000) begin miss++; $display("FAIL lb_type: got %b want 000", bus.mem_type); end
    @(negedge clk);
    vec++; if (bus.rsp_rdata !== 32'hFFFFFFFF) begin miss++; $display("FAIL lb_rdata: got %h want ffffffff", bus.rsp_rdata); end
    @(negedge clk);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    @(negedge clk);
    vec++; if (bus.rsp_rdata !== 32'h00000080) begin miss++; $display("FAIL lbu_rdata: got %h want 00000080", bus.rsp_rdata); end
    @(negedge clk);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    @(negedge clk);
    vec++; if (bus.rsp_rdata !== 32'hFFFF8000) begin miss++; $display("FAIL lh_rdata: got %h want ffff8000", bus.rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    @(negedge clk);
    vec++; if (bus.req_ready !== 1'b0 || bus.mem_ren !== 1'b1) begin miss++; $display("FAIL b2b_acc: got ready %b ren %b want 0 1", bus.req_ready, bus.mem_ren); end
    @(negedge clk);
    vec++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin miss++; $display("FAIL b2b_resp: got ready %b valid %b want 0 1", bus.req_ready, bus.rsp_valid); end
    @(negedge clk);
    vec++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_ren !== 1'b0) begin
      miss++; $display("FAIL b2b_idle: got ready %b valid %b ren %b want 1 0 0", bus.req_ready, bus.rsp_valid, bus.mem_ren); end
    @(negedge clk);
    vec++; if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h10) begin miss++; $display("FAIL b2b_second_acc: got ren %b addr %h want 1 00000010", bus.mem_ren, bus.mem_addr); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h800000FF) begin
      miss++; $display("FAIL b2b_second_rsp: got valid %b rdata %h want 1 800000ff", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue(1'b0, 3'b011, 32'h40, 32'h0);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin miss++; $display("FAIL ill_f3_rsp: got valid %b err %b want 1 1", bus.rsp_valid, bus.rsp_err); end
    vec++; if (bus.rsp_rdata !== 32'h0) begin miss++; $display("FAIL ill_f3_rdata: got %h want 0", bus.rsp_rdata); end
    vec++; if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) begin miss++; $display("FAIL ill_f3_strobe: got ren %b wen %b want 0 0", bus.mem_ren, bus.mem_wen); end
    @(negedge clk);
    vec++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miss++; $display("FAIL ill_f3_idle: got ready %b valid %b want 1 0", bus.req_ready, bus.rsp_valid); end
    issue(1'b1, 3'b100, 32'h40, 32'hFF);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.mem_wen !== 1'b0) begin
      miss++; $display("FAIL ill_store: got valid %b err %b wen %b want 1 1 0", bus.rsp_valid, bus.rsp_err, bus.mem_wen); end
    @(negedge clk);
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_split_load;
    poke(8'h13, 8'h34); poke(8'h14, 8'h92);
    issue(1'b0, 3'b001, 32'h13, 32'h0);
    vec++; if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h13 || bus.mem_type !== 3'b100) begin
      miss++; $display("FAIL lh_split_b0: got ren %b addr %h type %b want 1 00000013 100", bus.mem_ren, bus.mem_addr, bus.mem_type); end
    @(negedge clk);
    vec++; if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h14 || bus.mem_type !== 3'b100 || bus.rsp_valid !== 1'b0) begin
      miss++; $display("FAIL lh_split_b1: got ren %b addr %h type %b valid %b want 1 00000014 100 0",
                       bus.mem_ren, bus.mem_addr, bus.mem_type, bus.rsp_valid); end
    @(negedge clk);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFFFF9234) begin
      miss++; $display("FAIL lh_split_rsp: got valid %b rdata %h want 1 ffff9234", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
    issue(1'b0, 3'b101, 32'h13, 32'h0);
    @(negedge clk);
    @(negedge clk);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h00009234) begin
      miss++; $display("FAIL lhu_split_rsp: got valid %b rdata %h want 1 00009234", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h11, 32'h0);
    repeat (4) @(negedge clk);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h92340000) begin
      miss++; $display("FAIL lw_split_rsp: got valid %b rdata %h want 1 92340000", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_split_store;
    logic [31:0] wd;
    logic [7:0]  eb;
    wd = 32'hAABBCCDD;
    issue(1'b1, 3'b010, 32'h21, wd);
    for (int k = 0; k < 4; k++) begin
      eb = wd[8*k +: 8];
      vec++; if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 32'h21 + 32'(k) || bus.mem_type !== 3'b100 ||
                 bus.mem_wdata[7:0] !== eb) begin
        miss++; $display("FAIL sw_split_b%0d: got wen %b addr %h type %b byte %h want 1 %h 100 %h",
                         k, bus.mem_wen, bus.mem_addr, bus.mem_type, bus.mem_wdata[7:0], 32'h21 + 32'(k), eb); end
      @(negedge clk);
    end
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.mem_wen !== 1'b0) begin
      miss++; $display("FAIL sw_split_rsp: got valid %b err %b rdata %h wen %b want 1 0 0 0",
                       bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_wen); end
    @(negedge clk);
    vec++; if ({mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]} !== 32'hAABBCCDD) begin
      miss++; $display("FAIL sw_split_mem: got %h want aabbccdd", {mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]}); end
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 3'b010, 32'h21, 32'h11223344);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec++; if (bus.mem_wen !== 1'b0) begin miss++; $display("FAIL rmid_gate: got wen %b want 0", bus.mem_wen); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec++; if (bus.req_ready !== 1'b1 || bus.mem_addr !== 32'h0) begin miss++; $display("FAIL rmid_idle: got ready %b addr %h want 1 0", bus.req_ready, bus.mem_addr); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (bus.rsp_valid !== 1'b0) begin miss++; $display("FAIL rmid_no_rsp%0d: got %b want 0", i, bus.rsp_valid); end
      @(negedge clk);
    end
    vec++; if ({mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]} !== 32'hAABBCC44) begin
      miss++; $display("FAIL rmid_mem: got %h want aabbcc44", {mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]}); end
  endtask
`else
  task automatic test_misalign_off;
    issue(1'b0, 3'b010, 32'h22, 32'h0);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      miss++; $display("FAIL off_lw_rsp: got valid %b err %b rdata %h want 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    vec++; if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) begin miss++; $display("FAIL off_lw_strobe: got ren %b wen %b want 0 0", bus.mem_ren, bus.mem_wen); end
    @(negedge clk);
    issue(1'b1, 3'b001, 32'h13, 32'h1234);
    vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.mem_wen !== 1'b0) begin
      miss++; $display("FAIL off_sh_rsp: got valid %b err %b wen %b want 1 1 0", bus.rsp_valid, bus.rsp_err, bus.mem_wen); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 3'b010, 32'h30, 32'h11223344);
    rst = 1'b1;
    #1;
    vec++; if (bus.mem_wen !== 1'b0) begin miss++; $display("FAIL rmid_gate: got wen %b want 0", bus.mem_wen); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miss++; $display("FAIL rmid_idle: got ready %b valid %b want 1 0", bus.req_ready, bus.rsp_valid); end
    @(negedge clk);
    vec++; if (bus.rsp_valid !== 1'b0) begin miss++; $display("FAIL rmid_no_rsp: got %b want 0", bus.rsp_valid); end
    vec++; if ({mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} !== 32'h0) begin
      miss++; $display("FAIL rmid_mem: got %h want 0", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}); end
  endtask
`endif

  initial begin
    test_reset();
    test_aligned_load();
    test_back_to_back();
    test_illegal();
`ifdef LSU_MISALIGN_SPLIT_EN
    test_split_load();
    test_split_store();
`else
    test_misalign_off();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/lsu_split.md
LSU_SPLIT -- requirements
Module: lsu_split

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte-address width of req_addr and mem_addr.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: pipeline request handshake; transfer when both are 1 at a rising edge.
REQ-005 SHALL have ports req_we input 1 (1=store), req_funct3 input 3 (RISC-V load/store funct3), req_addr input ADDR_W, req_wdata input 32.
REQ-006 SHALL have ports rsp_valid output 1, rsp_rdata output 32, rsp_err output 1; the response has no backpressure.
REQ-007 SHALL have ports mem_wen output 1, mem_ren output 1, mem_addr output ADDR_W, mem_type output 3, mem_wdata output 32: the data-memory request, with mem_type[1:0] 00=byte, 01=half, 10=word and mem_type[2]=1 meaning unsigned.
REQ-008 SHALL have port mem_rdata input 32: the data-memory read data, combinational in the same cycle as mem_addr; memory writes occur on the rising edge.

Function
REQ-009 SHALL implement FSM states IDLE, ACC, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL, on request transfer in IDLE at cycle T, register we, funct3, addr and wdata, and go to ACC; illegal requests go directly to RESP.
REQ-011 SHALL treat funct3 011, 110 and 111, and any store with funct3[2]=1, as illegal: no memory access, rsp_err=1, rsp_rdata=0, rsp_valid at T+1.
REQ-012 SHALL classify a request as aligned when it is a byte access, a half access with addr[0]=0, or a word access with addr[1:0]=00.
REQ-013 SHALL serve an aligned request with a single ACC cycle (T+1): mem_addr=addr, mem_type=funct3, mem_wdata=wdata, ren or wen=1 as appropriate, and load data captured from mem_rdata.
REQ-014 SHALL serve a misaligned request in ACC as N byte accesses (N=2 half, 4 word), one per cycle, with k=0..N-1, mem_addr=addr+k (modulo 2^ADDR_W) and mem_type=100.
REQ-015 SHALL, on a split load, place mem_rdata[7:0] of byte k into bits [8k+7:8k] of the assembled value.
REQ-016 SHALL, on a split store, drive mem_wdata[7:0]=wdata[8k+7:8k] for byte k; upper mem_wdata bits are don't-care.
REQ-017 SHALL, after the last ACC cycle, spend exactly one cycle in RESP (rsp_valid=1) and then return to IDLE; aligned latency is T+2 and split latency is T+1+N.
REQ-018 SHALL extend load data in RESP: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged; rsp_rdata=0 for stores, with rsp_err=0.
REQ-019 SHALL hold mem_wen=mem_ren=0 outside ACC, and mem_addr, mem_type and mem_wdata at 0 in IDLE and RESP.
REQ-020 SHALL ignore req_valid outside IDLE; a request presented then SHALL stay pending until IDLE.

Reset
REQ-021 SHALL, when rst=1 at a rising edge, enter IDLE and clear all registers; after that edge req_ready=1 and rsp_valid=0, and every other output is 0.
REQ-022 SHALL gate mem_wen and mem_ren combinationally with ~rst, so no write occurs at the edge where reset is sampled; bytes of a split store already written stay written, and no response is produced for the aborted request.

Configuration
REQ-023 SHALL, with macro LSU_MISALIGN_SPLIT_EN defined, split misaligned accesses per REQ-014..016.
REQ-024 SHALL, without LSU_MISALIGN_SPLIT_EN, treat misaligned requests like illegal ones (REQ-011: no access, rsp_err=1 at T+1) and omit the byte-assembly logic.

Verification
REQ-025 SHALL cover reset: rst=1 for 2 cycles -> req_ready=1; rsp_valid, mem_wen, mem_ren and mem_addr all 0.
REQ-026 SHALL cover an aligned load: LW 0x10 with word 0x800000FF -> mem_addr=0x10, type=010 at T+1; rsp_valid at T+2 with rdata 0x800000FF; LB 0x10 -> 0xFFFFFFFF.
REQ-027 SHALL cover a split load: LH 0x13 with bytes 0x13=0x34 and 0x14=0x92 -> accesses at 0x13 then 0x14, type 100; rsp at T+3 with rdata 0xFFFF9234; LHU -> 0x00009234.
REQ-028 SHALL cover a split store: SW 0x21 with wdata 0xAABBCCDD -> byte writes 0x21=DD, 0x22=CC, 0x23=BB, 0x24=AA on T+1..T+4; rsp at T+5 with err=0.
REQ-029 SHALL cover illegal requests and macro-off behaviour: funct3=011 -> no mem strobe, rsp at T+1 with err=1 and rdata=0; with the macro off, LW 0x22 -> same.
REQ-030 SHALL cover reset mid-operation: rst during the 2nd cycle of the REQ-028 store -> only 0x21 written, IDLE next cycle, no rsp_valid.
